// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FSM state encoding, field widths and IEEE-754
// single-precision constants. Used by the divider and the multiplier.
package fpu_pkg;

   localparam int MANT_W = 24;
   localparam int EXP_W  = 10;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [31:0]             QNAN       = 32'hFFC00000;
   localparam logic signed [EXP_W-1:0] EXP_BIAS   = 10'sd127;
   localparam logic signed [EXP_W-1:0] EXP_MIN    = -10'sd126;
   localparam logic signed [EXP_W-1:0] EXP_MAX    = 10'sd127;

   typedef enum logic [3:0] {
      WAIT_REQ,
      UNPACK,
      SPECIAL_CASES,
      NORMALISE_A,
      NORMALISE_B,
      DIVIDE_0,
      DIVIDE_1,
      DIVIDE_2,
      NORMALISE_1,
      NORMALISE_2,
      ROUND,
      PACK,
      OUT_RDY
   } fpu_state_t;

   // Signed infinity or signed zero.
   function automatic logic [31:0] pack_signed(input logic s, input logic is_inf);
      pack_signed = {s, (is_inf ? 8'hFF : 8'h00), 23'd0};
   endfunction

endpackage

// File: rtl/fpu_div_rtl.sv
// IEEE-754 single-precision divider, multi-cycle FSM with inline restoring
// division (one quotient bit per cycle).
// Optional feature: define FPU_DIV_SUBNORMAL_EN to handle subnormal inputs and
// outputs; otherwise subnormal inputs are signed zero and underflow flushes.
module fpu_div_rtl
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] din1,
   input  logic [31:0] din2,
   input  logic        valid,
   output logic [31:0] result,
   output logic        ready
);

   fpu_state_t state_reg, state_next;

   logic [31:0]             a_in_reg, b_in_reg;
   logic [MANT_W-1:0]       a_m_reg, b_m_reg, z_m_reg;
   logic signed [EXP_W-1:0] a_e_reg, b_e_reg, z_e_reg;
   logic                    a_s_reg, b_s_reg, z_s_reg;
   logic                    guard_reg, round_reg, sticky_reg;
   logic [26:0]             q_reg;
   logic [24:0]             r_reg;
   logic [4:0]              count_reg;
   logic [31:0]             z_reg;
   logic [31:0]             result_reg;
   logic                    ready_reg;
   logic                    out_load;

   // Operand classification from the raw captured words.
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
   assign a_nan = (&a_in_reg[30:23]) &  (|a_in_reg[22:0]);
   assign b_nan = (&b_in_reg[30:23]) &  (|b_in_reg[22:0]);
   assign a_inf = (&a_in_reg[30:23]) & ~(|a_in_reg[22:0]);
   assign b_inf = (&b_in_reg[30:23]) & ~(|b_in_reg[22:0]);
`ifdef FPU_DIV_SUBNORMAL_EN
   assign a_zero = ~(|a_in_reg[30:0]);
   assign b_zero = ~(|b_in_reg[30:0]);
`else
   // Subnormals collapse to signed zero.
   assign a_zero = ~(|a_in_reg[30:23]);
   assign b_zero = ~(|b_in_reg[30:23]);
`endif
   assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

   // Restoring step: remainder stays below 2*divisor, so 25 bits suffice.
   logic        div_ge;
   logic [24:0] div_sub;
   assign div_ge  = r_reg >= {1'b0, b_m_reg};
   assign div_sub = r_reg - {1'b0, b_m_reg};

   logic [7:0] z_exp_field;
   assign z_exp_field = 8'(z_e_reg + EXP_BIAS);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= WAIT_REQ;
      else        state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         WAIT_REQ:      if (valid) state_next = UNPACK;
         UNPACK:        state_next = SPECIAL_CASES;
         SPECIAL_CASES: state_next = is_special ? OUT_RDY : NORMALISE_A;
         NORMALISE_A:   if (a_m_reg[23]) state_next = NORMALISE_B;
         NORMALISE_B:   if (b_m_reg[23]) state_next = DIVIDE_0;
         DIVIDE_0:      state_next = DIVIDE_1;
         DIVIDE_1:      if (count_reg == 5'd26) state_next = DIVIDE_2;
         DIVIDE_2:      state_next = NORMALISE_1;
         NORMALISE_1:   if (z_m_reg[23]) state_next = NORMALISE_2;
`ifdef FPU_DIV_SUBNORMAL_EN
         NORMALISE_2:   if (z_e_reg >= EXP_MIN) state_next = ROUND;
`else
         NORMALISE_2:   state_next = ROUND;
`endif
         ROUND:         state_next = PACK;
         PACK:          state_next = OUT_RDY;
         OUT_RDY:       state_next = WAIT_REQ;
         default:       state_next = WAIT_REQ;
      endcase
   end

   // Output decode: publish the packed word when leaving OUT_RDY.
   always_comb begin
      out_load = 1'b0;
      if (state_reg == OUT_RDY) out_load = 1'b1;
   end

   // Datapath registers, advanced according to the current state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_in_reg   <= '0;  b_in_reg  <= '0;
         a_m_reg    <= '0;  b_m_reg   <= '0;  z_m_reg    <= '0;
         a_e_reg    <= '0;  b_e_reg   <= '0;  z_e_reg    <= '0;
         a_s_reg    <= 1'b0; b_s_reg  <= 1'b0; z_s_reg   <= 1'b0;
         guard_reg  <= 1'b0; round_reg <= 1'b0; sticky_reg <= 1'b0;
         q_reg      <= '0;  r_reg     <= '0;  count_reg  <= '0;
         z_reg      <= '0;  result_reg <= '0; ready_reg  <= 1'b0;
      end else begin
         ready_reg <= out_load;
         if (out_load) result_reg <= z_reg;
         case (state_reg)
            WAIT_REQ: begin
               if (valid) begin
                  a_in_reg <= din1;
                  b_in_reg <= din2;
               end
            end
            UNPACK: begin
               a_s_reg <= a_in_reg[31];
               b_s_reg <= b_in_reg[31];
               a_m_reg <= {(|a_in_reg[30:23]), a_in_reg[22:0]};
               b_m_reg <= {(|b_in_reg[30:23]), b_in_reg[22:0]};
               a_e_reg <= (a_in_reg[30:23] == 8'd0) ? EXP_MIN
                          : $signed({2'b00, a_in_reg[30:23]}) - EXP_BIAS;
               b_e_reg <= (b_in_reg[30:23] == 8'd0) ? EXP_MIN
                          : $signed({2'b00, b_in_reg[30:23]}) - EXP_BIAS;
            end
            SPECIAL_CASES: begin
               if (a_nan | b_nan)       z_reg <= QNAN;
               else if (a_inf & b_inf)  z_reg <= QNAN;
               else if (a_zero & b_zero) z_reg <= QNAN;
               else if (a_inf)          z_reg <= pack_signed(a_s_reg ^ b_s_reg, 1'b1);
               else if (b_inf)          z_reg <= pack_signed(a_s_reg ^ b_s_reg, 1'b0);
               else if (b_zero)         z_reg <= pack_signed(a_s_reg ^ b_s_reg, 1'b1);
               else if (a_zero)         z_reg <= pack_signed(a_s_reg ^ b_s_reg, 1'b0);
            end
            NORMALISE_A: begin
               if (!a_m_reg[23]) begin
                  a_m_reg <= a_m_reg << 1;
                  a_e_reg <= a_e_reg - 10'sd1;
               end
            end
            NORMALISE_B: begin
               if (!b_m_reg[23]) begin
                  b_m_reg <= b_m_reg << 1;
                  b_e_reg <= b_e_reg - 10'sd1;
               end
            end
            DIVIDE_0: begin
               // Seeding the remainder with a_m and shifting in zeros is the
               // same as dividing a_m*2^26 one dividend bit per step.
               z_s_reg   <= a_s_reg ^ b_s_reg;
               z_e_reg   <= a_e_reg - b_e_reg;
               r_reg     <= {1'b0, a_m_reg};
               q_reg     <= '0;
               count_reg <= '0;
            end
            DIVIDE_1: begin
               q_reg     <= {q_reg[25:0], div_ge};
               r_reg     <= (div_ge ? div_sub : r_reg) << 1;
               count_reg <= count_reg + 5'd1;
            end
            DIVIDE_2: begin
               z_m_reg    <= q_reg[26:3];
               guard_reg  <= q_reg[2];
               round_reg  <= q_reg[1];
               sticky_reg <= q_reg[0] | (|r_reg);
            end
            NORMALISE_1: begin
               if (!z_m_reg[23]) begin
                  z_m_reg   <= {z_m_reg[22:0], guard_reg};
                  guard_reg <= round_reg;
                  round_reg <= 1'b0;
                  z_e_reg   <= z_e_reg - 10'sd1;
               end
            end
            NORMALISE_2: begin
`ifdef FPU_DIV_SUBNORMAL_EN
               if (z_e_reg < EXP_MIN) begin
                  z_e_reg    <= z_e_reg + 10'sd1;
                  z_m_reg    <= z_m_reg >> 1;
                  guard_reg  <= z_m_reg[0];
                  round_reg  <= guard_reg;
                  sticky_reg <= sticky_reg | round_reg;
               end
`endif
            end
            ROUND: begin
               if (guard_reg & (round_reg | sticky_reg | z_m_reg[0])) begin
                  z_m_reg <= z_m_reg + 24'd1;
                  if (z_m_reg == 24'hFFFFFF) z_e_reg <= z_e_reg + 10'sd1;
               end
            end
            PACK: begin
               if (z_e_reg > EXP_MAX)
                  z_reg <= pack_signed(z_s_reg, 1'b1);
`ifndef FPU_DIV_SUBNORMAL_EN
               else if (z_e_reg < EXP_MIN)
                  z_reg <= pack_signed(z_s_reg, 1'b0);
`endif
               else if ((z_e_reg == EXP_MIN) && !z_m_reg[23])
                  z_reg <= {z_s_reg, 8'd0, z_m_reg[22:0]};
               else
                  z_reg <= {z_s_reg, z_exp_field, z_m_reg[22:0]};
            end
            default: ;
         endcase
      end
   end

   assign result = result_reg;
   assign ready  = ready_reg;

endmodule

// File: tb/tb_fpu_div_rtl.sv
// Directed bench for fpu_div_rtl: table of operand pairs with hand-computed
// quotients and completion edges, plus reset-abort and busy-valid sequences.
module tb_fpu_div_rtl;

   logic        clk;
   logic        reset;
   logic [31:0] din1, din2;
   logic        valid;
   logic [31:0] result;
   logic        ready;

   int checks   = 0;
   int failures = 0;

   fpu_div_rtl dut (
      .clk    (clk),
      .reset  (reset),
      .din1   (din1),
      .din2   (din2),
      .valid  (valid),
      .result (result),
      .ready  (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          edge_n;
   } vec_t;

   vec_t vecs[14];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one request; count edges from the capture edge (edge 1) until
   // ready is seen. Optionally wiggle valid with junk operands while busy.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit toggle,
                         output logic [31:0] res, output int edge_n, output int after_ready);
      bit seen;
      din1  = a;
      din2  = b;
      valid = 1'b1;
      @(posedge clk);
      edge_n = 1;
      #1;
      valid = 1'b0;
      seen  = 1'b0;
      res   = 32'hDEADBEEF;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         edge_n++;
         #1;
         if (ready) begin
            seen = 1'b1;
            res  = result;
            break;
         end
         if (toggle) begin
            valid = ~valid;
            din1  = 32'h40C00000;
            din2  = 32'h40000000;
         end
      end
      valid = 1'b0;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL timeout: got no ready expected ready within 100 edges");
      end
      // One edge later ready must have dropped.
      @(posedge clk);
      #1;
      after_ready = int'(ready);
   endtask

   logic [31:0] res;
   int          edge_n;
   int          after_ready;
   int          pulses;

   initial begin
      reset = 1'b1;
      valid = 1'b0;
      din1  = '0;
      din2  = '0;

      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 39};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 40};
      vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4};
      vecs[3]  = '{32'h00000000, 32'h00000000, 32'hFFC00000, 4};
      vecs[4]  = '{32'h7FC00000, 32'h3F800000, 32'hFFC00000, 4};
      vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'hFFC00000, 4};
      vecs[6]  = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 4};
      vecs[7]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4};
      vecs[8]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4};
      vecs[9]  = '{32'hC1200000, 32'h40A00000, 32'hC0000000, 39};
      vecs[10] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 39};
      vecs[11] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 39};
`ifdef FPU_DIV_SUBNORMAL_EN
      vecs[12] = '{32'h00800000, 32'h40000000, 32'h00400000, 40};
      vecs[13] = '{32'h00400000, 32'h3F000000, 32'h00800000, 40};
`else
      vecs[12] = '{32'h00800000, 32'h40000000, 32'h00000000, 39};
      vecs[13] = '{32'h00400000, 32'h3F000000, 32'h00000000, 4};
`endif

      // Asynchronous reset: outputs clear without a clock edge.
      #1 reset = 1'b0;
      #1;
      check32("reset_result_async", result, 32'h0);
      check_int("reset_ready_async", int'(ready), 0);
      repeat (3) @(posedge clk);
      #1;
      check32("reset_result", result, 32'h0);
      check_int("reset_ready", int'(ready), 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].a, vecs[i].b, 1'b0, res, edge_n, after_ready);
         $display("vec %0d: %h / %h -> %h at edge %0d", i, vecs[i].a, vecs[i].b, res, edge_n);
         check32($sformatf("vec%0d_result", i), res, vecs[i].res);
         check_int($sformatf("vec%0d_edge", i), edge_n, vecs[i].edge_n);
         check_int($sformatf("vec%0d_pulse", i), after_ready, 0);
         check32($sformatf("vec%0d_hold", i), result, vecs[i].res);
      end

      // Reset during DIVIDE_1 (tenth division cycle): abort, no ready pulse.
      din1  = 32'h3F800000;
      din2  = 32'h40400000;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (14) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check32("abort_result_async", result, 32'h0);
      check_int("abort_ready_async", int'(ready), 0);
      repeat (2) @(posedge clk);
      #1;
      check32("abort_result", result, 32'h0);
      @(negedge clk) reset = 1'b1;
      pulses = 0;
      repeat (45) begin
         @(posedge clk);
         #1;
         if (ready) pulses++;
      end
      $display("abort: ready pulses after release %0d, result %h", pulses, result);
      check_int("abort_no_ready", pulses, 0);
      check32("abort_result_held", result, 32'h0);
      run_op(32'h40C00000, 32'h40000000, 1'b0, res, edge_n, after_ready);
      $display("post-abort: 40c00000 / 40000000 -> %h at edge %0d", res, edge_n);
      check32("post_abort_result", res, 32'h40400000);
      check_int("post_abort_edge", edge_n, 39);

      // valid wiggled with other operands while busy must be ignored.
      run_op(32'h3F800000, 32'h40400000, 1'b1, res, edge_n, after_ready);
      $display("busy-valid: 3f800000 / 40400000 -> %h at edge %0d", res, edge_n);
      check32("busy_result", res, 32'h3EAAAAAB);
      check_int("busy_edge", edge_n, 40);
      check_int("busy_pulse", after_ready, 0);
      pulses = 0;
      repeat (45) begin
         @(posedge clk);
         #1;
         if (ready) pulses++;
      end
      check_int("busy_no_extra_ready", pulses, 0);
      check32("busy_result_held", result, 32'h3EAAAAAB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_div_rtl.md
FPU_DIV_RTL -- requirements
Module: fpu_div_rtl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; reset==0 forces reset state immediately.
REQ-003 SHALL have port din1, input, 32 bits: IEEE-754 single dividend.
REQ-004 SHALL have port din2, input, 32 bits: IEEE-754 single divisor.
REQ-005 SHALL have port valid, input, 1 bit: request; din1/din2 captured when sampled high in WAIT_REQ.
REQ-006 SHALL have port result, output, 32 bits: quotient din1/din2; holds until next completion.
REQ-007 SHALL have port ready, output, 1 bit: one-cycle pulse, coincident with new result.

Function
REQ-008 SHALL sequence states WAIT_REQ, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B, DIVIDE_0, DIVIDE_1, DIVIDE_2, NORMALISE_1, NORMALISE_2, ROUND, PACK, OUT_RDY, then WAIT_REQ.
REQ-009 SHALL ignore valid in every state except WAIT_REQ; a request is accepted in the cycle ready is high.
REQ-010 SHALL drive ready low in WAIT_REQ; ready high for exactly one cycle after OUT_RDY, with result updated on the same edge.
REQ-011 SHALL unpack: mantissa 24 bits, exponent 10-bit signed (field-127), sign; exponent -127 nonzero mantissa = subnormal (exponent -126, no hidden bit); otherwise hidden bit set.
REQ-012 SHALL apply special cases in priority order, going directly to OUT_RDY: any NaN -> 0xFFC00000; inf/inf -> 0xFFC00000; 0/0 -> 0xFFC00000; inf/x -> inf, sign a_s^b_s; x/inf -> zero, sign a_s^b_s; x/0 -> inf, sign a_s^b_s; 0/x -> zero, sign a_s^b_s.
REQ-013 SHALL, in NORMALISE_A/B, shift mantissa left one bit per cycle, decrementing exponent, until bit 23 set.
REQ-014 SHALL, in DIVIDE_0, set z_s=a_s^b_s, z_e=a_e-b_e, load dividend a_m*2^26, divisor b_m, 5-bit iteration count.
REQ-015 SHALL run restoring division in DIVIDE_1, exactly one quotient bit per cycle, 27 cycles, producing q[26:0] and remainder r.
REQ-016 SHALL, in DIVIDE_2, set z_m=q[26:3], guard=q[2], round_bit=q[1], sticky=q[0] OR (r!=0).
REQ-017 SHALL, in NORMALISE_1, while z_m[23]==0 shift left injecting guard, guard<=round_bit, round_bit<=0, z_e-1; at most one shift for normal operands.
REQ-018 SHALL, in NORMALISE_2, while z_e < -126 shift right one bit, z_e+1, sticky accumulates shifted-out bits.
REQ-019 SHALL round to nearest even: increment z_m when guard AND (round_bit OR sticky OR z_m[0]); z_m==0xFFFFFF increment also increments z_e.
REQ-020 SHALL pack: exponent z_e+127; exponent field 0 when z_e==-126 and z_m[23]==0; z_e>127 -> inf with sign z_s.
REQ-021 SHALL complete normal/normal without NORMALISE_1 shift with ready high 39 rising edges after the capture edge inclusive; each extra normalise shift adds one cycle; special cases: 4 edges.

Reset
REQ-022 SHALL on reset==0 force state WAIT_REQ, ready=0, result=0x00000000, asynchronously.
REQ-023 SHALL abort any in-flight operation on reset with no ready pulse; first request after release processed normally.

Configuration
REQ-024 SHALL support macro FPU_DIV_SUBNORMAL_EN: defined -> subnormal inputs and outputs handled per REQ-011/018/020; undefined -> subnormal inputs treated as signed zero in SPECIAL_CASES and any result with z_e < -126 packed as signed zero, NORMALISE_2 not entered.

Structure
REQ-025 SHALL take state enum, field widths, bias 127, QNAN 0xFFC00000, exponent constants from shared package fpu_pkg, used also by the multiplier.
REQ-026 SHALL be a single module; no sub-module (restoring step inline).

Verification
REQ-027 0x40C00000 / 0x40000000 -> result 0x40400000, ready on edge 39, single-cycle pulse.
REQ-028 0x3F800000 / 0x40400000 -> result 0x3EAAAAAB (rounded up), ready on edge 40.
REQ-029 0x3F800000/0x00000000 -> 0x7F800000; 0x00000000/0x00000000 -> 0xFFC00000; 0x7FC00000/0x3F800000 -> 0xFFC00000; all on edge 4.
REQ-030 0x00800000 / 0x40000000 -> 0x00400000 with FPU_DIV_SUBNORMAL_EN; 0x00000000 without.
REQ-031 reset driven low on DIVIDE_1 cycle 10 -> ready stays 0, result 0x00000000; next request 0x40C00000/0x40000000 -> 0x40400000.
REQ-032 valid toggled during busy with other operands -> ignored; only first operands' result returned, one ready pulse.
